// File: rtl/dff_shift_bank.sv
// WIDTH-bit register bank with hold/load/shift/rotate/clear ops and a burst-shift
// engine that performs burst_len shifts autonomously, then pulses done.
module dff_shift_bank #(
  parameter int                 WIDTH   = 8,
  parameter int                 LEN_W   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              burst_dir,
  output logic [WIDTH-1:0]  q,
  output logic              sout_msb,
  output logic              sout_lsb,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROTL  = 3'b100;
  localparam logic [2:0] OP_ROTR  = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_BURST = 3'b111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [LEN_W-1:0]   count;
  logic               dir;

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

  // done defaults low every edge so it is a single-cycle pulse even while en=0
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= RST_VAL;
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      dir   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            case (mode)
              OP_HOLD:  q <= q;
              OP_LOAD:  q <= d;
              OP_SHL:   q <= {q[WIDTH-2:0], sin};
              OP_SHR:   q <= {sin, q[WIDTH-1:1]};
              OP_ROTL:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
              OP_ROTR:  q <= {q[0], q[WIDTH-1:1]};
              OP_CLEAR: q <= RST_VAL;
              OP_BURST: begin
                if (burst_len != '0) begin
                  count <= burst_len;
                  dir   <= burst_dir;
                  state <= BUSY;
                  busy  <= 1'b1;
                end else begin
                  done  <= 1'b1;
                end
              end
              default:  q <= q;
            endcase
          end
          BUSY: begin
            q <= dir ? {sin, q[WIDTH-1:1]} : {q[WIDTH-2:0], sin};
            if (count != '0) begin
              count <= count - LEN_W'(1);
            end
            if (count <= LEN_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dff_shift_bank.sv
// Self-checking bench for dff_shift_bank: directed scenarios plus a randomized run,
// all compared against an arithmetic reference model of the register bank.
module tb_dff_shift_bank;

  logic       clk = 1'b0;
  logic       rst, en, sin, burst_dir;
  logic [2:0] mode;
  logic [7:0] d, burst_len;
  logic [7:0] q;
  logic       sout_msb, sout_lsb, busy, done;

  int errors = 0;
  int checks = 0;

  // reference model state, plain integers
  int m_q = 0;
  int m_busy = 0;
  int m_left = 0;
  int m_dir = 0;
  int m_done = 0;

  dff_shift_bank #(.WIDTH(8), .LEN_W(8), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
    .burst_len(burst_len), .burst_dir(burst_dir), .q(q),
    .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int nd;
    int s;
    nd = 0;
    s = (sin === 1'b1) ? 1 : 0;
    if (rst) begin
      m_q = 0; m_busy = 0; m_left = 0; m_dir = 0;
    end else if (en) begin
      if (m_busy != 0) begin
        if (m_dir != 0) m_q = m_q / 2 + s * 128;
        else            m_q = (m_q * 2 + s) % 256;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 0;
          nd = 1;
        end
      end else begin
        case (mode)
          3'd1: m_q = int'(d);
          3'd2: m_q = (m_q * 2 + s) % 256;
          3'd3: m_q = m_q / 2 + s * 128;
          3'd4: m_q = (m_q * 2) % 256 + m_q / 128;
          3'd5: m_q = m_q / 2 + (m_q % 2) * 128;
          3'd6: m_q = 0;
          3'd7: begin
            if (burst_len != 0) begin
              m_busy = 1;
              m_left = int'(burst_len);
              m_dir  = burst_dir ? 1 : 0;
            end else begin
              nd = 1;
            end
          end
          default: m_q = m_q;
        endcase
      end
    end
    m_done = nd;
  endtask

  // one clock edge: model follows the same sampled inputs, outputs read 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; en = 1'b1; mode = 3'd0; sin = 1'b0;
    d = 8'h00; burst_len = 8'h00; burst_dir = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 3'd1; d = 8'hA5; tick();
    mode = 3'd7; burst_len = 8'd4; burst_dir = 1'b0; tick();
    mode = 3'd0;
    checks++;
    if (q !== 8'hA5 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_setup: q=%h busy=%b, required q=a5 busy=1", q, busy);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: q=%h busy=%b done=%b, required q=00 busy=0 done=0", q, busy, done);
    end
  endtask

  task automatic test_rotate();
    set_idle();
    mode = 3'd1; d = 8'h81; tick();
    mode = 3'd4; tick();
    checks++;
    if (q !== 8'h03) begin
      errors++;
      $display("[TB] FAIL rotl: q=%h, required 03", q);
    end
    mode = 3'd5; tick(); tick();
    mode = 3'd0;
    checks++;
    if (q !== 8'hC0) begin
      errors++;
      $display("[TB] FAIL rotr: q=%h, required c0", q);
    end
  endtask

  task automatic test_shift();
    set_idle();
    mode = 3'd6; tick();
    mode = 3'd2; sin = 1'b1;
    repeat (4) tick();
    checks++;
    if (q !== 8'h0F || sout_lsb !== 1'b1 || sout_msb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL shl: q=%h lsb=%b msb=%b, required q=0f lsb=1 msb=0", q, sout_lsb, sout_msb);
    end
    mode = 3'd3; sin = 1'b0; tick();
    mode = 3'd0;
    checks++;
    if (q !== 8'h07) begin
      errors++;
      $display("[TB] FAIL shr: q=%h, required 07", q);
    end
  endtask

  task automatic test_burst();
    int edges;
    int dones;
    set_idle();
    mode = 3'd1; d = 8'hF0; tick();
    mode = 3'd7; burst_len = 8'd3; burst_dir = 1'b1; sin = 1'b0; tick();
    edges = 1; dones = 0;
    while (busy === 1'b1 && edges < 40) begin
      mode = 3'($urandom_range(0, 7)); d = 8'($urandom); burst_len = 8'($urandom);
      burst_dir = 1'b0;
      tick();
      edges++;
      if (done === 1'b1) dones++;
    end
    mode = 3'd0;
    checks++;
    if (edges != 4 || q !== 8'h1E) begin
      errors++;
      $display("[TB] FAIL burst_basic: edges=%0d q=%h, required edges=4 q=1e", edges, q);
    end
    tick();
    checks++;
    if (dones != 1 || done !== 1'b0 || q !== 8'h1E) begin
      errors++;
      $display("[TB] FAIL burst_done: pulses=%0d done_after=%b q=%h, required 1 0 1e", dones, done, q);
    end
  endtask

  task automatic test_pause();
    int edges;
    int dones;
    set_idle();
    mode = 3'd1; d = 8'h5A; tick();
    mode = 3'd7; burst_len = 8'd5; burst_dir = 1'b0; tick();
    mode = 3'd0;
    edges = 1; dones = 0;
    while (busy === 1'b1 && edges < 40) begin
      en = (edges == 3 || edges == 4) ? 1'b0 : 1'b1;
      sin = 1'($urandom);
      tick();
      edges++;
      if (done === 1'b1) dones++;
    end
    en = 1'b1;
    tick();
    if (done === 1'b1) dones++;
    checks++;
    if (edges != 8 || dones != 1 || q !== 8'(m_q)) begin
      errors++;
      $display("[TB] FAIL burst_pause: edges=%0d pulses=%0d q=%h, required 8 1 %h", edges, dones, q, 8'(m_q));
    end
  endtask

  task automatic test_zero_and_abort();
    int dones;
    set_idle();
    mode = 3'd1; d = 8'h3C; tick();
    mode = 3'd7; burst_len = 8'd0; tick();
    mode = 3'd0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL burst_zero: done=%b busy=%b q=%h, required 1 0 3c", done, busy, q);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst_zero_pulse: done=%b, required 0", done);
    end
    mode = 3'd7; burst_len = 8'd6; burst_dir = 1'b0; sin = 1'b1; tick();
    mode = 3'd0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    dones = (done === 1'b1) ? 1 : 0;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst_abort: q=%h busy=%b done=%b, required 00 0 0", q, busy, done);
    end
    repeat (8) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || q !== 8'h00) begin
      errors++;
      $display("[TB] FAIL burst_abort_quiet: pulses=%0d q=%h, required 0 00", dones, q);
    end
  endtask

  task automatic test_random();
    set_idle();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      en        = ($urandom_range(0, 4) != 0);
      mode      = 3'($urandom_range(0, 7));
      d         = 8'($urandom);
      sin       = 1'($urandom);
      burst_len = 8'($urandom_range(0, 6));
      burst_dir = 1'($urandom);
      tick();
      checks++;
      if (q !== 8'(m_q) || busy !== 1'(m_busy) || done !== 1'(m_done) ||
          sout_msb !== q[7] || sout_lsb !== q[0]) begin
        errors++;
        $display("[TB] FAIL random[%0d]: q=%h busy=%b done=%b, required q=%h busy=%0d done=%0d",
                 i, q, busy, done, 8'(m_q), m_busy, m_done);
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_rotate();
    test_shift();
    test_burst();
    test_pause();
    test_zero_and_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
